// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared default constants and sizing helper for the fetch front end
package fetch_unit_pkg;
   localparam int          DEF_ADDR_W   = 16;
   localparam int          DEF_INSTR_W  = 16;
   localparam int          DEF_QDEPTH   = 4;
   localparam int unsigned DEF_RESET_PC = 0;
   localparam int unsigned DEF_PC_STEP  = 2;

   // Counters must hold the value QDEPTH itself, not just QDEPTH-1.
   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction
endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction-memory request/response and decode valid/ready bundle
interface fetch_unit_if
   import fetch_unit_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int INSTR_W = DEF_INSTR_W
) ();
   logic               imem_req;
   logic [ADDR_W-1:0]  imem_addr;
   logic               imem_gnt;
   logic               imem_rvalid;
   logic [INSTR_W-1:0] imem_rdata;
   logic               dec_valid;
   logic               dec_ready;
   logic [INSTR_W-1:0] dec_instr;
   logic [ADDR_W-1:0]  dec_pc;
   logic [ADDR_W-1:0]  dec_pc_next;

   modport master (
      output imem_req, imem_addr, dec_valid, dec_instr, dec_pc, dec_pc_next,
      input  imem_gnt, imem_rvalid, imem_rdata, dec_ready
   );

   modport slave (
      input  imem_req, imem_addr, dec_valid, dec_instr, dec_pc, dec_pc_next,
      output imem_gnt, imem_rvalid, imem_rdata, dec_ready
   );
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - circular fetch buffer: allocate at tail, fill oldest unfilled, pop at head
module fetch_queue
   import fetch_unit_pkg::*;
#(
   parameter int QDEPTH  = DEF_QDEPTH,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int INSTR_W = DEF_INSTR_W,
   localparam int CNT_W  = cnt_w(QDEPTH),
   localparam int PTR_W  = $clog2(QDEPTH)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               alloc,
   input  logic [ADDR_W-1:0]  alloc_pc,
   input  logic               fill,
   input  logic [INSTR_W-1:0] fill_instr,
   input  logic               pop,
   input  logic               flush,
   output logic               head_filled,
   output logic [ADDR_W-1:0]  head_pc,
   output logic [INSTR_W-1:0] head_instr,
   output logic [CNT_W-1:0]   alloc_cnt,
   output logic [CNT_W-1:0]   unfilled_cnt
);
   logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d, fptr_q, fptr_d;
   logic [CNT_W-1:0]   alloc_cnt_q, alloc_cnt_d, unfilled_q, unfilled_d;
   logic [QDEPTH-1:0]  filled_q, filled_d;
   logic [ADDR_W-1:0]  pc_mem_q [QDEPTH];
   logic [ADDR_W-1:0]  pc_mem_d [QDEPTH];
   logic [INSTR_W-1:0] instr_mem_q [QDEPTH];
   logic [INSTR_W-1:0] instr_mem_d [QDEPTH];

   always_comb begin
      head_d      = head_q;
      tail_d      = tail_q;
      fptr_d      = fptr_q;
      alloc_cnt_d = alloc_cnt_q;
      unfilled_d  = unfilled_q;
      filled_d    = filled_q;
      pc_mem_d    = pc_mem_q;
      instr_mem_d = instr_mem_q;
      if (flush) begin
         head_d      = '0;
         tail_d      = '0;
         fptr_d      = '0;
         alloc_cnt_d = '0;
         unfilled_d  = '0;
         filled_d    = '0;
      end else begin
         if (alloc) begin
            pc_mem_d[tail_q] = alloc_pc;
            filled_d[tail_q] = 1'b0;
            tail_d           = tail_q + PTR_W'(1);
         end
         if (fill) begin
            instr_mem_d[fptr_q] = fill_instr;
            filled_d[fptr_q]    = 1'b1;
            fptr_d              = fptr_q + PTR_W'(1);
         end
         // Clearing on pop keeps a stale flag from reappearing when head wraps.
         if (pop) begin
            filled_d[head_q] = 1'b0;
            head_d           = head_q + PTR_W'(1);
         end
         alloc_cnt_d = alloc_cnt_q + CNT_W'(alloc) - CNT_W'(pop);
         unfilled_d  = unfilled_q + CNT_W'(alloc) - CNT_W'(fill);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         head_q      <= '0;
         tail_q      <= '0;
         fptr_q      <= '0;
         alloc_cnt_q <= '0;
         unfilled_q  <= '0;
         filled_q    <= '0;
         pc_mem_q    <= '{default: '0};
         instr_mem_q <= '{default: '0};
      end else begin
         head_q      <= head_d;
         tail_q      <= tail_d;
         fptr_q      <= fptr_d;
         alloc_cnt_q <= alloc_cnt_d;
         unfilled_q  <= unfilled_d;
         filled_q    <= filled_d;
         pc_mem_q    <= pc_mem_d;
         instr_mem_q <= instr_mem_d;
      end
   end

   assign head_filled  = filled_q[head_q];
   assign head_pc      = pc_mem_q[head_q];
   assign head_instr   = instr_mem_q[head_q];
   assign alloc_cnt    = alloc_cnt_q;
   assign unfilled_cnt = unfilled_q;
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC, in-order fetch issue, stale-response dropping and redirect control
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int          ADDR_W   = DEF_ADDR_W,
   parameter int          INSTR_W  = DEF_INSTR_W,
   parameter int          QDEPTH   = DEF_QDEPTH,
   parameter int unsigned RESET_PC = DEF_RESET_PC,
   parameter int unsigned PC_STEP  = DEF_PC_STEP
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   fetch_unit_if.master      bus
);
   localparam int                CNT_W   = cnt_w(QDEPTH);
   localparam int                SUM_W   = CNT_W + 1;
   localparam logic [SUM_W-1:0]  DEPTH_C = SUM_W'(QDEPTH);
   localparam logic [ADDR_W-1:0] STEP_C  = ADDR_W'(PC_STEP);

   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [CNT_W-1:0]   drop_q, drop_d;
   logic [CNT_W-1:0]   alloc_cnt, unfilled_cnt;
   logic               head_filled;
   logic [ADDR_W-1:0]  head_pc;
   logic [INSTR_W-1:0] head_instr;
   logic               resp_any, resp_drop, resp_fill, grant, pop;

   // A response with nothing outstanding is a protocol error and is ignored.
   assign resp_drop = bus.imem_rvalid && (drop_q != '0);
   assign resp_fill = bus.imem_rvalid && (drop_q == '0) && (unfilled_cnt != '0);
   assign resp_any  = resp_drop || resp_fill;

   assign bus.imem_req  = reset_n && !redirect_valid &&
                          (({1'b0, alloc_cnt} + {1'b0, drop_q}) < DEPTH_C);
   assign bus.imem_addr = pc_q;
   assign grant         = bus.imem_req && bus.imem_gnt;
   assign pop           = head_filled && bus.dec_ready;

   fetch_queue #(
      .QDEPTH (QDEPTH),
      .ADDR_W (ADDR_W),
      .INSTR_W(INSTR_W)
   ) u_queue (
      .clk         (clk),
      .reset_n     (reset_n),
      .alloc       (grant),
      .alloc_pc    (pc_q),
      .fill        (resp_fill),
      .fill_instr  (bus.imem_rdata),
      .pop         (pop),
      .flush       (redirect_valid),
      .head_filled (head_filled),
      .head_pc     (head_pc),
      .head_instr  (head_instr),
      .alloc_cnt   (alloc_cnt),
      .unfilled_cnt(unfilled_cnt)
   );

   always_comb begin
      pc_d   = pc_q;
      drop_d = drop_q;
      if (redirect_valid) begin
         // Every request still unanswered becomes a stale response to discard.
         pc_d   = redirect_pc;
         drop_d = drop_q + unfilled_cnt - CNT_W'(resp_any);
      end else begin
         if (grant)     pc_d   = pc_q + STEP_C;
         if (resp_drop) drop_d = drop_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc_q   <= ADDR_W'(RESET_PC);
         drop_q <= '0;
      end else begin
         pc_q   <= pc_d;
         drop_q <= drop_d;
      end
   end

   assign bus.dec_valid   = head_filled;
   assign bus.dec_instr   = head_instr;
   assign bus.dec_pc      = head_pc;
   assign bus.dec_pc_next = head_pc + STEP_C;
endmodule
